// File: rtl/acc_seq_pkg.sv
// Shared types and the step load-mask rule for the accumulator sequencer.
package acc_seq_pkg;

   localparam int WIDTH_DEF = 6;
   localparam int NW_DEF    = 4;
   localparam int STEP_W    = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      M_ALL  = 2'd0,
      M_EVEN = 2'd1,
      M_REF  = 2'd2,
      M_ODD  = 2'd3
   } mode_t;

   function automatic logic step_mask(input mode_t m, input logic [STEP_W-1:0] i);
      logic ld;
      case (m)
         M_ALL:   ld = 1'b1;
         M_EVEN:  ld = ~i[0];
         M_REF:   ld = i[0] | (i == {STEP_W{1'b0}});
         M_ODD:   ld = i[0];
         default: ld = 1'b0;
      endcase
      return ld;
   endfunction

endpackage

// File: rtl/acc_datapath.sv
// Count register B and accumulator W with shared adder S = W + B.
import acc_seq_pkg::*;

module acc_datapath #(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             cnt,
   input  logic             load_w,
   output logic [WIDTH-1:0] W,
   output logic [WIDTH-1:0] B
);

   localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] w_r;
   logic [WIDTH-1:0] sum_s;

   // Adder uses the pre-increment B, so W accumulates the old count.
   assign sum_s = w_r + b_r;

   // B/W registers: clr dominates cnt and load_w.
   always_ff @(posedge clk) begin
      if (reset) begin
         b_r <= {WIDTH{1'b0}};
         w_r <= {WIDTH{1'b0}};
      end else if (clr) begin
         b_r <= {WIDTH{1'b0}};
         w_r <= {WIDTH{1'b0}};
      end else begin
         if (cnt) begin
            b_r <= b_r + ONE_W;
         end
         if (load_w) begin
            w_r <= sum_s;
         end
      end
   end

   assign W = w_r;
   assign B = b_r;

endmodule

// File: rtl/acc_seq_ctrl.sv
// Start/done handshaked sequencer running N masked accumulate steps on acc_datapath.
import acc_seq_pkg::*;

module acc_seq_ctrl #(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NW    = NW_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [NW-1:0]    n_steps,
   input  logic [1:0]       mode,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam logic [NW-1:0] ONE_N = {{(NW-1){1'b0}}, 1'b1};

   state_t           state_r;
   state_t           state_next_s;
   logic [NW-1:0]    n_r;
   mode_t            mode_r;
   logic [NW-1:0]    i_r;
   logic             busy_r;
   logic             done_r;
   logic             clr_s;
   logic             cnt_s;
   logic             load_w_s;
   logic             last_step_s;
   logic [WIDTH-1:0] w_s;
   logic [WIDTH-1:0] b_s;

   assign last_step_s = (i_r == (n_r - ONE_N));

   // Next-state and datapath control decode.
   always_comb begin
      state_next_s = state_r;
      clr_s        = 1'b0;
      cnt_s        = 1'b0;
      load_w_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               clr_s        = 1'b1;
               state_next_s = (n_steps == {NW{1'b0}}) ? DONE : RUN;
            end else begin
               state_next_s = IDLE;
            end
         end
         RUN: begin
            cnt_s    = 1'b1;
            load_w_s = step_mask(mode_r, STEP_W'(i_r));
            if (abort) begin
               state_next_s = IDLE;
            end else if (last_step_s) begin
               state_next_s = DONE;
            end else begin
               state_next_s = RUN;
            end
         end
         DONE: begin
            state_next_s = IDLE;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State, run parameters, step index and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         n_r     <= {NW{1'b0}};
         mode_r  <= M_ALL;
         i_r     <= {NW{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy_r  <= (state_next_s != IDLE);
         done_r  <= (state_next_s == DONE);
         if (state_r == IDLE && start) begin
            n_r    <= n_steps;
            mode_r <= mode_t'(mode);
            i_r    <= {NW{1'b0}};
         end else if (state_r == RUN && state_next_s == RUN) begin
            // i only advances while another step follows, so it stays <= N-1.
            i_r <= i_r + ONE_N;
         end
      end
   end

   acc_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr_s),
      .cnt    (cnt_s),
      .load_w (load_w_s),
      .W      (w_s),
      .B      (b_s)
   );

   assign busy   = busy_r;
   assign done   = done_r;
   assign result = w_s;

endmodule
